tx_tail_ctrl: RTL
=================

TX_TAIL_CTRL -- requirements
Module: tx_tail_ctrl

Interface
REQ-001 clk  input  1  rising-edge system clock.
REQ-002 n_rst  input  1  asynchronous, active-low reset.
REQ-003 head_ptr  input  3  write-side index of the next free slot, legal range 0..5.
REQ-004 head_tog  input  1  write-side wrap toggle; inverts each time head_ptr wraps 5->0.
REQ-005 rd_ready  input  1  consumer requests one entry this cycle.
REQ-006 flush  input  1  discard all stored entries.
REQ-007 clr_err  input  1  clears the sticky underrun flag; present only with TX_UNDERRUN_DET_EN.
REQ-008 rd_valid  output  1  an entry is available at rd_addr.
REQ-009 rd_addr  output  3  storage index to read; equals tail_ptr.
REQ-010 tail_ptr  output  3  read index, range 0..5.
REQ-011 tail_tog  output  1  read wrap toggle.
REQ-012 empty  output  1  no stored entries.
REQ-013 full  output  1  six stored entries.
REQ-014 count  output  3  number of stored entries, 0..6.
REQ-015 underrun_err  output  1  sticky pop-while-empty flag.

Function
REQ-016 A pop SHALL occur on a clock edge where rd_ready=1, rd_valid=1 and flush=0.
REQ-017 On a pop, tail_ptr SHALL advance 0->1->2->3->4->5->0 at that edge, and tail_tog SHALL invert at the 5->0 wrap only.
REQ-018 empty SHALL be 1 iff tail_ptr==head_ptr and tail_tog==head_tog.
REQ-019 full SHALL be 1 iff tail_ptr==head_ptr and tail_tog!=head_tog.
REQ-020 count SHALL be head_ptr-tail_ptr when the toggles are equal, and 6-tail_ptr+head_ptr when they differ.
REQ-021 rd_valid SHALL be ~empty, rd_addr SHALL be tail_ptr, and empty, full, count and rd_valid SHALL all be combinational from registered tail state and the head inputs (zero latency).
REQ-022 rd_ready with empty=1 SHALL NOT move tail_ptr or tail_tog.
REQ-023 flush=1 SHALL load tail_ptr<=head_ptr and tail_tog<=head_tog at the next edge; flush takes priority over a simultaneous pop; empty=1 the following cycle.
REQ-024 A pop while full SHALL be legal, and full SHALL deassert the next cycle.
REQ-025 A simultaneous write-side push and pop SHALL leave count unchanged after the edge.
REQ-026 head_ptr values 6..7 are illegal; the bench assertion SHALL flag them, and the RTL gives no defined response.

Reset
REQ-027 When n_rst is low: tail_ptr=0, tail_tog=0 and underrun_err=0, asynchronously; with the head inputs at reset this SHALL give empty=1, full=0, count=0 and rd_valid=0.
REQ-028 Reset asserted mid-operation SHALL abort any pending pop or flush, and no partial pointer update SHALL persist.

Configuration
REQ-029 With TX_UNDERRUN_DET_EN defined: underrun_err SHALL set at the edge where rd_ready=1 and empty=1, hold until clr_err=1, and on simultaneous set and clear the set SHALL win.
REQ-030 Without TX_UNDERRUN_DET_EN: the clr_err port SHALL be absent, underrun_err SHALL be tied 0, and no flop SHALL be inferred for it.

Structure
REQ-031 Package tx_fifo_pkg SHALL hold FIFO_DEPTH=6, PTR_W=3, PTR_MAX=3'd5 and the typedef ptr_t (logic [2:0]), shared with the head-side logic.
REQ-032 The single sub-module tx_ptr_mod6 SHALL provide a mod-6 counter with enable, synchronous load (value plus toggle), and toggle output; tx_tail_ctrl SHALL instantiate it once.

Verification
REQ-033 Reset, then head=0/tog=0 -> empty=1, count=0, rd_valid=0, tail=0/0.
REQ-034 head=3/tog=0, rd_ready=1 for 3 cycles -> tail 1, 2, 3; count 2, 1, 0; empty=1 after the third pop.
REQ-035 tail=5/0, head=1/1 (count=2), one pop -> tail=0/tog=1, count=1.
REQ-036 head=4/1 with tail=4/0 -> full=1, count=6; one pop -> full=0, count=5, tail=5/0.
REQ-037 tail=2/0, head=5/0, flush=1 together with rd_ready=1 -> tail=5/0, empty=1, no pop counted.
REQ-038 With TX_UNDERRUN_DET_EN, empty and rd_ready=1 -> underrun_err=1 next cycle, held through 5 idle cycles; clr_err=1 with rd_ready=1 on the same cycle -> underrun_err stays 1; clr_err alone -> 0.

Source files
------------

// File: rtl/tx_fifo_pkg.sv
// Shared TX FIFO geometry: six entries addressed by a 3-bit index plus a wrap toggle.
package tx_fifo_pkg;
    localparam int FIFO_DEPTH = 6;
    localparam int PTR_W      = 3;
    typedef logic [PTR_W-1:0] ptr_t;
    localparam ptr_t PTR_MAX  = 3'd5;
endpackage

// File: rtl/tx_ptr_mod6.sv
// Mod-6 index counter with wrap toggle, enable and synchronous load (load wins over enable).
module tx_ptr_mod6
    import tx_fifo_pkg::*;
(
    input  logic clk,
    input  logic n_rst,
    input  logic en,
    input  logic load,
    input  ptr_t load_val,
    input  logic load_tog,
    output ptr_t ptr,
    output logic tog
);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ptr <= '0;
            tog <= 1'b0;
        end else if (load) begin
            ptr <= load_val;
            tog <= load_tog;
        end else if (en) begin
            if (ptr == PTR_MAX) begin
                ptr <= '0;
                tog <= ~tog;
            end else begin
                ptr <= ptr + 3'd1;
            end
        end
    end

endmodule

// File: rtl/tx_tail_ctrl.sv
// Read-side (tail) control of the 6-entry TX FIFO; occupancy flags are combinational.
// Optional sticky underrun detection with clr_err port: define TX_UNDERRUN_DET_EN.
module tx_tail_ctrl
    import tx_fifo_pkg::*;
(
    input  logic clk,
    input  logic n_rst,
    input  ptr_t head_ptr,
    input  logic head_tog,
    input  logic rd_ready,
    input  logic flush,
`ifdef TX_UNDERRUN_DET_EN
    input  logic clr_err,
`endif
    output logic rd_valid,
    output ptr_t rd_addr,
    output ptr_t tail_ptr,
    output logic tail_tog,
    output logic empty,
    output logic full,
    output ptr_t count,
    output logic underrun_err
);

    localparam ptr_t DEPTH_P = ptr_t'(FIFO_DEPTH);

    logic pop;
    logic same_idx;

    assign same_idx = (tail_ptr == head_ptr);
    assign empty    = same_idx && (tail_tog == head_tog);
    assign full     = same_idx && (tail_tog != head_tog);
    assign rd_valid = ~empty;
    assign rd_addr  = tail_ptr;
    // flush takes priority: a pop is suppressed so the load alone decides the next tail
    assign pop      = rd_ready && !empty && !flush;

    always_comb begin
        count = '0;
        if (tail_tog == head_tog)
            count = head_ptr - tail_ptr;
        else
            count = DEPTH_P - tail_ptr + head_ptr;
    end

    tx_ptr_mod6 u_tail (
        .clk      (clk),
        .n_rst    (n_rst),
        .en       (pop),
        .load     (flush),
        .load_val (head_ptr),
        .load_tog (head_tog),
        .ptr      (tail_ptr),
        .tog      (tail_tog)
    );

`ifdef TX_UNDERRUN_DET_EN
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            underrun_err <= 1'b0;
        else if (rd_ready && empty)
            underrun_err <= 1'b1;
        else if (clr_err)
            underrun_err <= 1'b0;
    end
`else
    assign underrun_err = 1'b0;
`endif

endmodule
